// File: rtl/hpdcache_mshr_mt.sv
// Multi-target MSHR: per-(set,way) line tracking with merged targets replayed on refill.
// Optional statistics counters are enabled by defining HPDCACHE_MSHR_MT_STATS_EN.
module hpdcache_mshr_mt #(
    parameter int SETS    = 4,
    parameter int WAYS    = 4,
    parameter int TARGETS = 4,
    parameter int NLINE_W = 32,
    parameter int TID_W   = 8,
    parameter int SID_W   = 3,
    parameter int WORD_W  = 3,
    localparam int SET_W  = (SETS > 1) ? $clog2(SETS) : 1,
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1,
    localparam int CNT_W  = $clog2(TARGETS + 1)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    output logic               empty_o,
    output logic               full_o,
    input  logic               check_i,
    input  logic [NLINE_W-1:0] check_nline_i,
    output logic               hit_o,
    output logic [WAY_W-1:0]   hit_way_o,
    output logic               merge_ok_o,
    output logic               alloc_full_o,
    input  logic               alloc_i,
    input  logic               alloc_merge_i,
    input  logic [NLINE_W-1:0] alloc_nline_i,
    input  logic [TID_W-1:0]   alloc_req_id_i,
    input  logic [SID_W-1:0]   alloc_src_id_i,
    input  logic [WORD_W-1:0]  alloc_word_i,
    input  logic               alloc_need_rsp_i,
    input  logic               alloc_is_prefetch_i,
    output logic [WAY_W-1:0]   alloc_way_o,
    input  logic               ack_i,
    input  logic [SET_W-1:0]   ack_set_i,
    input  logic [WAY_W-1:0]   ack_way_i,
    output logic               ack_busy_o,
    output logic               ack_valid_o,
    input  logic               ack_ready_i,
    output logic               ack_last_o,
    output logic [NLINE_W-1:0] ack_nline_o,
    output logic [TID_W-1:0]   ack_req_id_o,
    output logic [SID_W-1:0]   ack_src_id_o,
    output logic [WORD_W-1:0]  ack_word_o,
    output logic               ack_need_rsp_o,
    output logic               ack_is_prefetch_o,
`ifdef HPDCACHE_MSHR_MT_STATS_EN
    output logic [31:0]        stat_alloc_o,
    output logic [31:0]        stat_merge_o,
`endif
    output logic [0:0]         dbg_state_o
);
    localparam int IDX_W = (TARGETS > 1) ? $clog2(TARGETS) : 1;
    localparam int TAG_W = (SETS > 1) ? NLINE_W - SET_W : NLINE_W;
    localparam int TGT_W = TID_W + SID_W + WORD_W + 2;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    // Handshake: a target moves when ack_valid_o && ack_ready_i at a rising clk_i;
    // while ack_valid_o is high and ack_ready_i is low the payload is held stable.

    logic             valid [SETS][WAYS];
    logic [TAG_W-1:0] tag   [SETS][WAYS];
    logic [CNT_W-1:0] cnt   [SETS][WAYS];
    logic [TGT_W-1:0] tgt   [SETS][WAYS][TARGETS];

    logic [SET_W-1:0] chk_set;
    logic [TAG_W-1:0] chk_tag;
    logic [0:0]       state;
    logic [SET_W-1:0] drn_set;
    logic [WAY_W-1:0] drn_way;
    logic [IDX_W-1:0] drn_idx;

    logic [SET_W-1:0] check_set, alloc_set;
    logic [TAG_W-1:0] check_tag, alloc_tag;
    logic             draining, free_any, new_ok, merge_acc, ack_ok;
    logic [WAY_W-1:0] free_way;
    logic [TGT_W-1:0] payload, cur;

    assign draining = (state == ST_DRAIN);

    if (SETS > 1) begin : g_split
        assign check_set   = check_nline_i[SET_W-1:0];
        assign check_tag   = check_nline_i[NLINE_W-1:SET_W];
        assign alloc_set   = alloc_nline_i[SET_W-1:0];
        assign alloc_tag   = alloc_nline_i[NLINE_W-1:SET_W];
        assign ack_nline_o = draining ? {tag[drn_set][drn_way], drn_set} : '0;
    end else begin : g_noset
        assign check_set   = '0;
        assign check_tag   = check_nline_i;
        assign alloc_set   = '0;
        assign alloc_tag   = alloc_nline_i;
        assign ack_nline_o = draining ? tag[drn_set][drn_way] : '0;
    end

    // Descending scans so the lowest matching/free way is the last one written.
    always_comb begin
        hit_o        = 1'b0;
        hit_way_o    = '0;
        alloc_full_o = 1'b1;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid[chk_set][w] && (tag[chk_set][w] == chk_tag)) begin
                hit_o     = 1'b1;
                hit_way_o = WAY_W'(w);
            end
            if (!valid[chk_set][w]) alloc_full_o = 1'b0;
        end
    end

    always_comb begin
        free_any = 1'b0;
        free_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid[alloc_set][w]) begin
                free_any = 1'b1;
                free_way = WAY_W'(w);
            end
        end
    end

    always_comb begin
        empty_o = 1'b1;
        full_o  = 1'b1;
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
                if (valid[s][w]) empty_o = 1'b0;
                else             full_o  = 1'b0;
            end
        end
    end

    assign merge_ok_o = hit_o && (cnt[chk_set][hit_way_o] < CNT_W'(TARGETS)) &&
                        !(draining && (drn_set == chk_set) && (drn_way == hit_way_o));

    assign new_ok      = alloc_i && !alloc_merge_i && free_any;
    assign merge_acc   = alloc_i && alloc_merge_i && merge_ok_o;
    assign ack_ok      = ack_i && !draining && !alloc_i && valid[ack_set_i][ack_way_i];
    assign alloc_way_o = !alloc_i ? '0 : (alloc_merge_i ? hit_way_o : free_way);
    assign payload     = {alloc_req_id_i, alloc_src_id_i, alloc_word_i,
                          alloc_need_rsp_i, alloc_is_prefetch_i};

    assign ack_busy_o  = draining;
    assign ack_valid_o = draining;
    assign ack_last_o  = draining &&
                         (CNT_W'(drn_idx) == cnt[drn_set][drn_way] - CNT_W'(1));
    assign cur         = draining ? tgt[drn_set][drn_way][drn_idx] : '0;
    assign {ack_req_id_o, ack_src_id_o, ack_word_o, ack_need_rsp_o, ack_is_prefetch_o} = cur;
    assign dbg_state_o = state;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid[s][w] <= 1'b0;
                    tag[s][w]   <= '0;
                    cnt[s][w]   <= '0;
                end
            end
            chk_set <= '0;
            chk_tag <= '0;
            state   <= ST_IDLE;
            drn_set <= '0;
            drn_way <= '0;
            drn_idx <= '0;
        end else begin
            // An alloc in the same cycle wins; the previous check stays registered.
            if (check_i && !alloc_i) begin
                chk_set <= check_set;
                chk_tag <= check_tag;
            end
            if (new_ok) begin
                valid[alloc_set][free_way] <= 1'b1;
                tag[alloc_set][free_way]   <= alloc_tag;
                cnt[alloc_set][free_way]   <= CNT_W'(1);
            end
            if (merge_acc) begin
                cnt[chk_set][hit_way_o] <= cnt[chk_set][hit_way_o] + CNT_W'(1);
            end
            case (state)
                ST_IDLE: begin
                    if (ack_ok) begin
                        state   <= ST_DRAIN;
                        drn_set <= ack_set_i;
                        drn_way <= ack_way_i;
                        drn_idx <= '0;
                    end
                end
                default: begin
                    if (ack_ready_i) begin
                        if (ack_last_o) begin
                            valid[drn_set][drn_way] <= 1'b0;
                            cnt[drn_set][drn_way]   <= '0;
                            state                   <= ST_IDLE;
                        end else begin
                            drn_idx <= drn_idx + IDX_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    // Target payloads need no reset: they are only visible while draining a valid entry.
    always_ff @(posedge clk_i) begin
        if (new_ok) tgt[alloc_set][free_way][0] <= payload;
        if (merge_acc) tgt[chk_set][hit_way_o][cnt[chk_set][hit_way_o][IDX_W-1:0]] <= payload;
    end

`ifdef HPDCACHE_MSHR_MT_STATS_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stat_alloc_o <= '0;
            stat_merge_o <= '0;
        end else begin
            if (new_ok && (stat_alloc_o != '1)) stat_alloc_o <= stat_alloc_o + 32'd1;
            if (merge_acc && (stat_merge_o != '1)) stat_merge_o <= stat_merge_o + 32'd1;
        end
    end
`endif

    a_ack_busy:    assert property (@(posedge clk_i) disable iff (!rst_ni) !(ack_i && draining));
    a_ack_invalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                    !(ack_i && !valid[ack_set_i][ack_way_i]));
    a_ack_alloc:   assert property (@(posedge clk_i) disable iff (!rst_ni) !(ack_i && alloc_i));
    a_merge_bad:   assert property (@(posedge clk_i) disable iff (!rst_ni)
                                    !(alloc_i && alloc_merge_i && !merge_ok_o));
    a_alloc_full:  assert property (@(posedge clk_i) disable iff (!rst_ni)
                                    !(alloc_i && !alloc_merge_i && !free_any));
endmodule

// File: tb/tb_hpdcache_mshr_mt.sv
// Scoreboard bench for hpdcache_mshr_mt: directed scenarios plus randomized check/alloc/drain traffic.
module tb_hpdcache_mshr_mt;
    localparam int SETS    = 4;
    localparam int WAYS    = 2;
    localparam int TARGETS = 4;
    localparam int NLINE_W = 32;
    localparam int EXP_W   = 1 + NLINE_W + 16;

    typedef struct packed {
        logic [7:0] tid;
        logic [2:0] sid;
        logic [2:0] word;
        logic       need_rsp;
        logic       pf;
    } tgt_t;

    logic        clk, rst_n;
    logic        empty_o, full_o, check_i, hit_o, merge_ok_o, alloc_full_o;
    logic [31:0] check_nline_i, alloc_nline_i, ack_nline_o;
    logic [0:0]  hit_way_o, alloc_way_o, ack_way_i;
    logic        alloc_i, alloc_merge_i, alloc_need_rsp_i, alloc_is_prefetch_i;
    logic [7:0]  alloc_req_id_i, ack_req_id_o;
    logic [2:0]  alloc_src_id_i, alloc_word_i, ack_src_id_o, ack_word_o;
    logic        ack_i, ack_busy_o, ack_valid_o, ack_ready_i, ack_last_o;
    logic [1:0]  ack_set_i;
    logic        ack_need_rsp_o, ack_is_prefetch_o;
    logic [0:0]  dbg_state_o;
`ifdef HPDCACHE_MSHR_MT_STATS_EN
    logic [31:0] stat_alloc_o, stat_merge_o;
`endif

    hpdcache_mshr_mt #(.SETS(SETS), .WAYS(WAYS), .TARGETS(TARGETS), .NLINE_W(NLINE_W),
                       .TID_W(8), .SID_W(3), .WORD_W(3)) dut (
        .clk_i(clk), .rst_ni(rst_n), .empty_o(empty_o), .full_o(full_o),
        .check_i(check_i), .check_nline_i(check_nline_i), .hit_o(hit_o),
        .hit_way_o(hit_way_o), .merge_ok_o(merge_ok_o), .alloc_full_o(alloc_full_o),
        .alloc_i(alloc_i), .alloc_merge_i(alloc_merge_i), .alloc_nline_i(alloc_nline_i),
        .alloc_req_id_i(alloc_req_id_i), .alloc_src_id_i(alloc_src_id_i),
        .alloc_word_i(alloc_word_i), .alloc_need_rsp_i(alloc_need_rsp_i),
        .alloc_is_prefetch_i(alloc_is_prefetch_i), .alloc_way_o(alloc_way_o),
        .ack_i(ack_i), .ack_set_i(ack_set_i), .ack_way_i(ack_way_i),
        .ack_busy_o(ack_busy_o), .ack_valid_o(ack_valid_o), .ack_ready_i(ack_ready_i),
        .ack_last_o(ack_last_o), .ack_nline_o(ack_nline_o), .ack_req_id_o(ack_req_id_o),
        .ack_src_id_o(ack_src_id_o), .ack_word_o(ack_word_o),
        .ack_need_rsp_o(ack_need_rsp_o), .ack_is_prefetch_o(ack_is_prefetch_o),
`ifdef HPDCACHE_MSHR_MT_STATS_EN
        .stat_alloc_o(stat_alloc_o), .stat_merge_o(stat_merge_o),
`endif
        .dbg_state_o(dbg_state_o)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: entries hold full line numbers and an ordered target list.
    bit          m_valid [SETS][WAYS];
    logic [31:0] m_nline [SETS][WAYS];
    int          m_cnt   [SETS][WAYS];
    tgt_t        m_tgt   [SETS][WAYS][TARGETS];
    bit          m_busy;
    int          m_ds, m_dw;
    logic [31:0] m_chk;
    int          m_stat_alloc, m_stat_merge;
    logic [EXP_W-1:0] exp_q[$];
    int          errors, checks;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic int m_hit_way(input logic [31:0] n);
        int s = int'(n % SETS);
        for (int w = 0; w < WAYS; w++)
            if (m_valid[s][w] && m_nline[s][w] == n) return w;
        return -1;
    endfunction

    function automatic int m_free_way(input int s);
        for (int w = 0; w < WAYS; w++)
            if (!m_valid[s][w]) return w;
        return -1;
    endfunction

    function automatic bit m_merge_ok();
        int s  = int'(m_chk % SETS);
        int hw = m_hit_way(m_chk);
        return (hw >= 0) && (m_cnt[s][hw] < TARGETS) && !(m_busy && m_ds == s && m_dw == hw);
    endfunction

    function automatic bit m_any(input bit want_valid);
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
                if (m_valid[s][w] == want_valid) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_clear();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 1'b0;
                m_cnt[s][w]   = 0;
            end
        m_busy = 1'b0; m_chk = '0; m_stat_alloc = 0; m_stat_merge = 0;
        exp_q.delete();
    endtask

    // Driver tasks (all start and end just after a falling edge)
    task automatic do_reset();
        rst_n = 1'b0;
        check_i = 1'b0; alloc_i = 1'b0; ack_i = 1'b0; ack_ready_i = 1'b0;
        model_clear();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic check_results(input string tag);
        int s  = int'(m_chk % SETS);
        int hw = m_hit_way(m_chk);
        chk({tag, "_hit"}, hit_o, hw >= 0);
        if (hw >= 0) chk({tag, "_hit_way"}, hit_way_o, hw);
        chk({tag, "_merge_ok"}, merge_ok_o, m_merge_ok());
        chk({tag, "_alloc_full"}, alloc_full_o, m_free_way(s) < 0);
        chk({tag, "_empty"}, empty_o, !m_any(1'b1));
        chk({tag, "_full"}, full_o, !m_any(1'b0));
    endtask

    task automatic do_check(input logic [31:0] n);
        check_i = 1'b1; check_nline_i = n;
        tick();
        check_i = 1'b0;
        m_chk = n;
        check_results("check");
    endtask

    task automatic do_alloc(input logic [31:0] n, input bit merge, input tgt_t p);
        int s = int'(n % SETS);
        int way;
        bit ok;
        if (merge) begin
            way = m_hit_way(m_chk); ok = m_merge_ok(); s = int'(m_chk % SETS);
        end else begin
            way = m_free_way(s); ok = (way >= 0);
        end
        alloc_i = 1'b1; alloc_merge_i = merge; alloc_nline_i = n;
        {alloc_req_id_i, alloc_src_id_i, alloc_word_i, alloc_need_rsp_i, alloc_is_prefetch_i} = p;
        #1;
        chk("alloc_way", alloc_way_o, (way < 0) ? 0 : way);
        tick();
        alloc_i = 1'b0;
        if (ok) begin
            if (!merge) begin
                m_valid[s][way] = 1'b1; m_nline[s][way] = n; m_cnt[s][way] = 0;
                m_stat_alloc++;
            end else m_stat_merge++;
            m_tgt[s][way][m_cnt[s][way]] = p;
            m_cnt[s][way]++;
        end
    endtask

    task automatic do_ack(input int s, input int w);
        ack_i = 1'b1; ack_set_i = 2'(s); ack_way_i = 1'(w);
        for (int i = 0; i < m_cnt[s][w]; i++)
            exp_q.push_back({(i == m_cnt[s][w] - 1), m_nline[s][w], m_tgt[s][w][i]});
        m_busy = 1'b1; m_ds = s; m_dw = w;
        tick();
        ack_i = 1'b0;
        chk("ack_busy_start", ack_busy_o, 1);
        chk("ack_valid_start", ack_valid_o, 1);
    endtask

    task automatic drain_wait();
        int n = 0;
        while (m_busy && n < 200) begin
            ack_ready_i = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        ack_ready_i = 1'b0;
        checks++;
        if (m_busy) begin
            errors++;
            $display("FAIL drain_timeout: still busy after %0d cycles, required idle", n);
        end
        chk("busy_after_drain", ack_busy_o, 0);
    endtask

    function automatic tgt_t rand_tgt();
        return tgt_t'($urandom_range(0, 65535));
    endfunction

    // Monitor: every presented target is compared with the queue head; pops on handshake.
    initial begin
        logic [EXP_W-1:0] act;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && ack_valid_o) begin
                act = {ack_last_o, ack_nline_o, ack_req_id_o, ack_src_id_o, ack_word_o,
                       ack_need_rsp_o, ack_is_prefetch_o};
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL ack_unexpected: got %0h with no target required", act);
                end else begin
                    chk(ack_ready_i ? "ack_pop" : "ack_hold", act, exp_q[0]);
                    if (ack_ready_i) begin
                        void'(exp_q.pop_front());
                        if (exp_q.size() == 0) begin
                            m_valid[m_ds][m_dw] = 1'b0; m_cnt[m_ds][m_dw] = 0; m_busy = 1'b0;
                        end
                    end
                end
            end
        end
    end

    task automatic chk_reset_state();
        chk("rst_empty", empty_o, 1);
        chk("rst_full", full_o, 0);
        chk("rst_hit", hit_o, 0);
        chk("rst_hit_way", hit_way_o, 0);
        chk("rst_merge_ok", merge_ok_o, 0);
        chk("rst_alloc_full", alloc_full_o, 0);
        chk("rst_alloc_way", alloc_way_o, 0);
        chk("rst_busy", ack_busy_o, 0);
        chk("rst_valid", ack_valid_o, 0);
        chk("rst_last", ack_last_o, 0);
        chk("rst_nline", ack_nline_o, 0);
        chk("rst_req_id", ack_req_id_o, 0);
`ifdef HPDCACHE_MSHR_MT_STATS_EN
        chk("rst_stat_alloc", stat_alloc_o, 0);
        chk("rst_stat_merge", stat_merge_o, 0);
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pat[5] = '{1, 0, 1, 1, 1};
        errors = 0; checks = 0;
        check_nline_i = '0; alloc_nline_i = '0; alloc_merge_i = 1'b0;
        alloc_req_id_i = '0; alloc_src_id_i = '0; alloc_word_i = '0;
        alloc_need_rsp_i = 1'b0; alloc_is_prefetch_i = 1'b0;
        ack_set_i = '0; ack_way_i = '0;
        @(negedge clk);
        do_reset();
        chk_reset_state();

        // Lookup / allocation basics and set-full detection
        do_check(32'h40);
        chk("tp_miss", hit_o, 0);
        do_alloc(32'h40, 1'b0, rand_tgt());
        chk("tp_not_empty", empty_o, 0);
        do_alloc(32'h4, 1'b0, rand_tgt());
        do_check(32'h8);
        chk("tp_set_full", alloc_full_o, 1);
        do_check(32'h1);
        chk("tp_set_free", alloc_full_o, 0);

        // Primary + three merges, then the entry is target-full
        do_reset();
        do_check(32'h10);
        do_alloc(32'h10, 1'b0, tgt_t'({8'd1, 8'h00}));
        for (int t = 2; t <= 4; t++) begin
            do_check(32'h10);
            do_alloc(32'h10, 1'b1, tgt_t'({8'(t), 3'(t), 3'(t), 2'b01}));
        end
        do_check(32'h10);
        chk("tp_full_hit", hit_o, 1);
        chk("tp_full_merge_ok", merge_ok_o, 0);

        // Drain with stalled ready while other traffic proceeds
        do_ack(0, 0);
        do_check(32'h10);
        chk("tp_drain_merge_ok", merge_ok_o, 0);
        do_alloc(32'h11, 1'b0, rand_tgt());
        for (int i = 0; i < 5; i++) begin
            ack_ready_i = 1'(pat[i]);
            tick();
        end
        ack_ready_i = 1'b0;
        chk("tp_drain_done_busy", ack_busy_o, 0);
        chk("tp_drain_queue", exp_q.size(), 0);
        do_check(32'h10);
        chk("tp_drained_miss", hit_o, 0);
        do_check(32'h11);

        // Randomized traffic
        for (int it = 0; it < 300; it++) begin
            logic [31:0] n;
            int op, hw, s0, w0;
            bit found;
            n  = 32'($urandom_range(0, 15));
            op = $urandom_range(0, 3);
            if (op == 0) begin
                found = 1'b0; s0 = 0; w0 = 0;
                for (int k = 0; k < SETS * WAYS && !found; k++) begin
                    int e = (k + $urandom_range(0, SETS * WAYS - 1)) % (SETS * WAYS);
                    if (m_valid[e / WAYS][e % WAYS]) begin
                        found = 1'b1; s0 = e / WAYS; w0 = e % WAYS;
                    end
                end
                if (found) begin
                    do_ack(s0, w0);
                    drain_wait();
                end
            end else begin
                do_check(n);
                hw = m_hit_way(n);
                if (hw >= 0) begin
                    if (m_merge_ok()) do_alloc(n, 1'b1, rand_tgt());
                end else if (m_free_way(int'(n % SETS)) >= 0) begin
                    do_alloc(n, 1'b0, rand_tgt());
                end
            end
        end

`ifdef HPDCACHE_MSHR_MT_STATS_EN
        chk("stat_alloc", stat_alloc_o, m_stat_alloc);
        chk("stat_merge", stat_merge_o, m_stat_merge);
`endif

        // Reset in the middle of a drain
        if (!m_any(1'b1)) begin
            do_check(32'h5);
            do_alloc(32'h5, 1'b0, rand_tgt());
        end
        for (int e = 0; e < SETS * WAYS; e++) begin
            if (m_valid[e / WAYS][e % WAYS] && !m_busy) do_ack(e / WAYS, e % WAYS);
        end
        do_reset();
        chk_reset_state();
        chk("end_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
